// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses PLL reset, waits for a settled lock, then releases
// downstream domain resets in a staggered order; any lock loss or relock request restarts it.
module pll_lock_supervisor #(
  parameter int NUM_DOMAINS    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 20000,
  parameter int SETTLE_CYCLES  = 256,
  parameter int STAGGER_CYCLES = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   LOCKED_IN,
  input  logic                   RELOCK_REQ,
  output logic                   PLL_RST,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RST,
  output logic                   READY,
  output logic [CNT_WIDTH-1:0]   LOSS_COUNT,
  output logic [CNT_WIDTH-1:0]   TIMEOUT_COUNT,
  output logic [2:0]             STATE
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_SETTLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  localparam logic [31:0] RST_LEN   = 32'(PLL_RST_CYCLES);
  localparam logic [31:0] TMO_LAST  = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0] SET_LAST  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] STG_LAST  = 32'(STAGGER_CYCLES - 1);
  localparam logic [31:0] LAST_IDX  = 32'(NUM_DOMAINS - 1);
  localparam state_t      FIRST_REL = (NUM_DOMAINS == 1) ? S_RUN : S_RELEASE;

  state_t state, state_nx;
  logic [31:0] timer, timer_nx;
  logic [31:0] idx, idx_nx;
  logic sync1, lk;
  logic loss_inc, tmo_inc;
  logic pll_rst_nx, ready_nx;
  logic [NUM_DOMAINS-1:0] dom_rst_nx;

  always_ff @(posedge CLK) begin
    sync1 <= LOCKED_IN;
    lk    <= sync1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= S_RESET_PLL;
      timer         <= '0;
      idx           <= '0;
      LOSS_COUNT    <= '0;
      TIMEOUT_COUNT <= '0;
      PLL_RST       <= 1'b1;
      DOMAIN_RST    <= '1;
      READY         <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      idx        <= idx_nx;
      PLL_RST    <= pll_rst_nx;
      DOMAIN_RST <= dom_rst_nx;
      READY      <= ready_nx;
      if (loss_inc && !(&LOSS_COUNT))
        LOSS_COUNT <= LOSS_COUNT + CNT_WIDTH'(1);
      if (tmo_inc && !(&TIMEOUT_COUNT))
        TIMEOUT_COUNT <= TIMEOUT_COUNT + CNT_WIDTH'(1);
    end
  end

  // Entering RESET_PLL loads timer=1 because the entry edge is the pulse's first cycle;
  // after RST the count starts at 0 so the pulse spans PLL_RST_CYCLES edges past release.
  always_comb begin
    state_nx = state;
    timer_nx = timer + 32'd1;
    idx_nx   = idx;
    loss_inc = 1'b0;
    tmo_inc  = 1'b0;
    case (state)
      S_RESET_PLL: begin
        if (timer >= RST_LEN) begin
          state_nx = S_WAIT_LOCK;
          timer_nx = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (lk) begin
          if (SETTLE_CYCLES <= 1) begin
            state_nx = FIRST_REL;
            timer_nx = '0;
            idx_nx   = '0;
          end else begin
            state_nx = S_SETTLE;
            timer_nx = 32'd1;
          end
        end else if (timer >= TMO_LAST) begin
          state_nx = S_RESET_PLL;
          timer_nx = 32'd1;
          tmo_inc  = 1'b1;
        end
      end
      S_SETTLE: begin
        if (!lk) begin
          state_nx = S_WAIT_LOCK;
          timer_nx = '0;
        end else if (timer >= SET_LAST) begin
          state_nx = FIRST_REL;
          timer_nx = '0;
          idx_nx   = '0;
        end
      end
      S_RELEASE: begin
        if (timer >= STG_LAST) begin
          timer_nx = '0;
          idx_nx   = idx + 32'd1;
          if (idx + 32'd1 >= LAST_IDX)
            state_nx = S_RUN;
        end
      end
      S_RUN: timer_nx = '0;
      default: begin
        state_nx = S_RESET_PLL;
        timer_nx = 32'd1;
      end
    endcase

    if ((state == S_RELEASE || state == S_RUN) && !lk) begin
      state_nx = S_RESET_PLL;
      timer_nx = 32'd1;
      idx_nx   = '0;
      loss_inc = 1'b1;
    end else if (RELOCK_REQ && state != S_RESET_PLL) begin
      state_nx = S_RESET_PLL;
      timer_nx = 32'd1;
      idx_nx   = '0;
      tmo_inc  = 1'b0;
    end
  end

  always_comb begin
    pll_rst_nx = (state_nx == S_RESET_PLL);
    ready_nx   = (state_nx == S_RUN);
    dom_rst_nx = '1;
    for (int i = 0; i < NUM_DOMAINS; i++)
      dom_rst_nx[i] = !(state_nx == S_RUN ||
                        (state_nx == S_RELEASE && $unsigned(i) <= idx_nx));
  end

  assign STATE = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: timed expectations are queued per cycle and
// compared against the registered outputs on the falling edge.
module tb_pll_lock_supervisor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked_in = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst;
  logic [2:0] domain_rst;
  logic       ready;
  logic [3:0] loss_count;
  logic [3:0] timeout_count;
  logic [2:0] state;

  pll_lock_supervisor #(
    .NUM_DOMAINS(3), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(100),
    .SETTLE_CYCLES(16), .STAGGER_CYCLES(8), .CNT_WIDTH(4)
  ) dut (
    .CLK(clk), .RST(rst), .LOCKED_IN(locked_in), .RELOCK_REQ(relock_req),
    .PLL_RST(pll_rst), .DOMAIN_RST(domain_rst), .READY(ready),
    .LOSS_COUNT(loss_count), .TIMEOUT_COUNT(timeout_count), .STATE(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    bit          drv;
    bit          lock;
    bit          req;
    bit          chk;
    logic [15:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [15:0] exp;
    string       name;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [15:0] pk(logic pll, logic [2:0] dom, logic rdy,
                                     logic [2:0] st, logic [3:0] loss, logic [3:0] tmo);
    return {pll, dom, rdy, st, loss, tmo};
  endfunction

  function automatic logic [3:0] sat15(int k);
    return (k > 15) ? 4'd15 : 4'(k);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc > 20000) begin
      $display("FAIL cycle_budget cyc=%0d limit=20000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic at(int c);
    while (cyc < c) step();
  endtask

  task automatic expect_now(string nm, logic [15:0] e);
    sb_t s;
    s.cyc = cyc; s.exp = e; s.name = nm;
    sb.push_back(s);
  endtask

  task automatic row(int a, bit d, bit l, bit r, bit c, logic [15:0] e, string nm);
    vec_t v;
    v.at = a; v.drv = d; v.lock = l; v.req = r; v.chk = c; v.exp = e; v.name = nm;
    tbl.push_back(v);
  endtask

  always @(negedge clk) begin
    sb_t         e;
    logic [15:0] got;
    got = {pll_rst, domain_rst, ready, state, loss_count, timeout_count};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || got !== e.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d got pll=%b dom=%b rdy=%b st=%0d loss=%0d tmo=%0d want pll=%b dom=%b rdy=%b st=%0d loss=%0d tmo=%0d",
                 e.name, cyc, got[15], got[14:12], got[11], got[10:8], got[7:4], got[3:0],
                 e.exp[15], e.exp[14:12], e.exp[11], e.exp[10:8], e.exp[7:4], e.exp[3:0]);
      end
    end
  end

  initial begin
    int b;
    int g;
    int t;
    b = 3;

    // clean start, loss in RUN, lone relock request, request coinciding with loss
    row(0,   1, 0, 0, 1, pk(1, 3'b111, 0, 3'd0, 4'd0, 4'd0), "reset_state");
    row(4,   0, 0, 0, 1, pk(1, 3'b111, 0, 3'd0, 4'd0, 4'd0), "pll_rst_hold");
    row(5,   0, 0, 0, 1, pk(0, 3'b111, 0, 3'd1, 4'd0, 4'd0), "pll_rst_fall");
    row(20,  1, 1, 0, 1, pk(0, 3'b111, 0, 3'd1, 4'd0, 4'd0), "wait_lock");
    row(22,  0, 0, 0, 1, pk(0, 3'b111, 0, 3'd1, 4'd0, 4'd0), "sync_latency");
    row(23,  0, 0, 0, 1, pk(0, 3'b111, 0, 3'd2, 4'd0, 4'd0), "settle_entry");
    row(37,  0, 0, 0, 1, pk(0, 3'b111, 0, 3'd2, 4'd0, 4'd0), "settle_end");
    row(38,  0, 0, 0, 1, pk(0, 3'b110, 0, 3'd3, 4'd0, 4'd0), "release_d0");
    row(45,  0, 0, 0, 1, pk(0, 3'b110, 0, 3'd3, 4'd0, 4'd0), "stagger_d1_pre");
    row(46,  0, 0, 0, 1, pk(0, 3'b100, 0, 3'd3, 4'd0, 4'd0), "release_d1");
    row(53,  0, 0, 0, 1, pk(0, 3'b100, 0, 3'd3, 4'd0, 4'd0), "stagger_d2_pre");
    row(54,  0, 0, 0, 1, pk(0, 3'b000, 1, 3'd4, 4'd0, 4'd0), "release_d2_ready");
    row(60,  1, 0, 0, 1, pk(0, 3'b000, 1, 3'd4, 4'd0, 4'd0), "run_hold");
    row(62,  0, 0, 0, 1, pk(0, 3'b000, 1, 3'd4, 4'd0, 4'd0), "loss_pending");
    row(63,  0, 0, 0, 1, pk(1, 3'b111, 0, 3'd0, 4'd1, 4'd0), "loss_response");
    row(66,  0, 0, 0, 1, pk(1, 3'b111, 0, 3'd0, 4'd1, 4'd0), "loss_pll_hold");
    row(67,  0, 0, 0, 1, pk(0, 3'b111, 0, 3'd1, 4'd1, 4'd0), "loss_pll_fall");
    row(70,  1, 1, 0, 0, 16'h0, "relock");
    row(87,  0, 0, 0, 1, pk(0, 3'b111, 0, 3'd2, 4'd1, 4'd0), "relock_settle");
    row(88,  0, 0, 0, 1, pk(0, 3'b110, 0, 3'd3, 4'd1, 4'd0), "relock_d0");
    row(104, 0, 0, 0, 1, pk(0, 3'b000, 1, 3'd4, 4'd1, 4'd0), "relock_ready");
    row(110, 1, 1, 1, 0, 16'h0, "req_pulse");
    row(111, 1, 1, 0, 1, pk(1, 3'b111, 0, 3'd0, 4'd1, 4'd0), "req_response");
    row(115, 0, 0, 0, 1, pk(0, 3'b111, 0, 3'd1, 4'd1, 4'd0), "req_wait");
    row(116, 0, 0, 0, 1, pk(0, 3'b111, 0, 3'd2, 4'd1, 4'd0), "req_settle");
    row(130, 0, 0, 0, 1, pk(0, 3'b111, 0, 3'd2, 4'd1, 4'd0), "req_settle_end");
    row(131, 0, 0, 0, 1, pk(0, 3'b110, 0, 3'd3, 4'd1, 4'd0), "req_d0");
    row(147, 0, 0, 0, 1, pk(0, 3'b000, 1, 3'd4, 4'd1, 4'd0), "req_ready");
    row(150, 1, 0, 0, 0, 16'h0, "both_drop");
    row(152, 1, 0, 1, 1, pk(0, 3'b000, 1, 3'd4, 4'd1, 4'd0), "both_pending");
    row(153, 1, 0, 0, 1, pk(1, 3'b111, 0, 3'd0, 4'd2, 4'd0), "both_counted_once");
    row(157, 0, 0, 0, 1, pk(0, 3'b111, 0, 3'd1, 4'd2, 4'd0), "both_wait");

    at(b);
    rst = 1'b0;
    foreach (tbl[i]) begin
      at(b + tbl[i].at);
      if (tbl[i].chk) expect_now(tbl[i].name, tbl[i].exp);
      if (tbl[i].drv) begin
        locked_in  = tbl[i].lock;
        relock_req = tbl[i].req;
      end
    end

    // lock glitch during settle must restart the settle count without a loss event
    g = b + 170;
    at(g);      locked_in = 1'b1;
    at(g + 10); locked_in = 1'b0;
    at(g + 12); expect_now("glitch_settle", pk(0, 3'b111, 0, 3'd2, 4'd2, 4'd0));
    at(g + 13); expect_now("glitch_back_wait", pk(0, 3'b111, 0, 3'd1, 4'd2, 4'd0));
    locked_in = 1'b1;
    at(g + 16); expect_now("glitch_resettle", pk(0, 3'b111, 0, 3'd2, 4'd2, 4'd0));
    at(g + 30); expect_now("glitch_no_early_rel", pk(0, 3'b111, 0, 3'd2, 4'd2, 4'd0));
    at(g + 31); expect_now("glitch_release", pk(0, 3'b110, 0, 3'd3, 4'd2, 4'd0));

    // reset in the middle of the release stagger
    at(g + 33); expect_now("pre_mid_rst", pk(0, 3'b110, 0, 3'd3, 4'd2, 4'd0));
    rst = 1'b1;
    at(g + 34); expect_now("mid_rst_state", pk(1, 3'b111, 0, 3'd0, 4'd0, 4'd0));
    rst = 1'b0;
    at(g + 38); expect_now("mid_rst_pll_hold", pk(1, 3'b111, 0, 3'd0, 4'd0, 4'd0));
    at(g + 39); expect_now("mid_rst_pll_fall", pk(0, 3'b111, 0, 3'd1, 4'd0, 4'd0));
    at(g + 40); expect_now("mid_rst_settle", pk(0, 3'b111, 0, 3'd2, 4'd0, 4'd0));

    // lock held low: periodic timeouts, counter saturates at 15
    at(g + 41); locked_in = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      t = g + 144 + 104 * (k - 1);
      at(t - 1); expect_now("timeout_pre", pk(0, 3'b111, 0, 3'd1, 4'd0, sat15(k - 1)));
      at(t);     expect_now("timeout_pulse", pk(1, 3'b111, 0, 3'd0, 4'd0, sat15(k)));
      at(t + 4); expect_now("timeout_pll_fall", pk(0, 3'b111, 0, 3'd1, 4'd0, sat15(k)));
    end

    at(cyc + 3);
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain pending=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
